// File: rtl/game_pkg.sv
// Shared game types: player ids, board coordinates, bomb slot record,
// movement directions, and the fuse-step helper used by the bomb scheduler.
package game_pkg;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    typedef logic [7:0] coord_t;
    typedef logic [1:0] power_t;
    typedef logic [3:0] fuse_t;

    typedef struct packed {
        logic    valid;
        logic    expired;
        player_t owner;
        coord_t  coord;
        power_t  power;
        fuse_t   fuse;
    } slot_t;

    typedef enum logic [2:0] {
        UP    = 3'd0,
        DOWN  = 3'd1,
        LEFT  = 3'd2,
        RIGHT = 3'd3,
        STOP  = 3'd4
    } dir_t;

    typedef enum logic {
        EXP_IDLE    = 1'b0,
        EXP_PRESENT = 1'b1
    } exp_state_t;

    // One fuse step: count down and flag expiry when the fuse leaves 1.
    function automatic slot_t slot_tick(input slot_t s);
        slot_t r;
        r = s;
        if (s.fuse != 4'd0) begin
            r.fuse = s.fuse - 4'd1;
        end else begin
            r.fuse = 4'd0;
        end
        if (s.fuse <= 4'd1) begin
            r.expired = 1'b1;
        end else begin
            r.expired = s.expired;
        end
        return r;
    endfunction

endpackage

// File: rtl/bomb_slot_finder.sv
// Combinational lowest-index search over a request vector.
module bomb_slot_finder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            found = found | req[i];
            if (req[i]) begin
                idx = W'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/bomb_scheduler.sv
// Shared bomb slot table: captures placement requests from both players,
// arbitrates them into free slots, counts fuses down on the game tick and
// hands expired bombs one at a time to the explosion block.
module bomb_scheduler
    import game_pkg::*;
#(
    parameter int NUM_SLOTS  = 8,
    parameter int FUSE_TICKS = 3,
    parameter int SLOT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       p1_set_bomb,
    input  logic [7:0] p1_coordinate,
    input  logic [1:0] p1_power,
    input  logic       p2_set_bomb,
    input  logic [7:0] p2_coordinate,
    input  logic [1:0] p2_power,
    input  logic [2:0] bomb_max_1,
    input  logic [2:0] bomb_max_2,
    input  logic       det_valid,
    input  logic [7:0] det_coord,
    output logic [2:0] bomb_num_1,
    output logic [2:0] bomb_num_2,
    output logic       explode_valid,
    input  logic       explode_ready,
    output logic [7:0] explode_coord,
    output logic [1:0] explode_power,
    output logic       explode_owner
);

    slot_t               slots_r     [NUM_SLOTS];
    slot_t               slots_nxt_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] free_vec_s;
    logic [NUM_SLOTS-1:0] exp_vec_s;
    logic [NUM_SLOTS-1:0] match_vec_s;

    logic                free_found_s;
    logic [SLOT_W-1:0]   free_idx_s;
    logic                exp_found_s;
    logic [SLOT_W-1:0]   exp_sel_idx_s;

    logic   [1:0]        pend_valid_r;
    coord_t              pend_coord_r [2];
    power_t              pend_power_r [2];
    logic   [1:0]        set_s;
    coord_t              set_coord_s  [2];
    power_t              set_power_s  [2];
    player_t             rr_r;

    logic                contested_s;
    logic                gnt_any_s;
    player_t             gnt_player_s;
    coord_t              gnt_coord_s;
    power_t              gnt_power_s;
    logic   [2:0]        gnt_count_s;
    logic   [2:0]        gnt_max_s;
    logic                hit_s;
    logic                limit_s;
    logic                insert_s;
    logic                retire_s;

    logic   [2:0]        num_1_r;
    logic   [2:0]        num_2_r;
    logic   [2:0]        num_1_nxt_s;
    logic   [2:0]        num_2_nxt_s;

    exp_state_t          state_r;
    exp_state_t          state_nxt_s;
    logic                load_s;
    logic                free_s;
    logic                exp_valid_r;
    coord_t              exp_coord_r;
    power_t              exp_power_r;
    player_t             exp_owner_r;
    logic [SLOT_W-1:0]   exp_idx_r;

    assign set_s[0]       = p1_set_bomb;
    assign set_s[1]       = p2_set_bomb;
    assign set_coord_s[0] = p1_coordinate;
    assign set_coord_s[1] = p2_coordinate;
    assign set_power_s[0] = p1_power;
    assign set_power_s[1] = p2_power;

    // Per-slot status vectors feeding the finders and the duplicate check.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_vec_s[i]  = ~slots_r[i].valid;
            exp_vec_s[i]   = slots_r[i].valid & slots_r[i].expired;
            match_vec_s[i] = slots_r[i].valid & (slots_r[i].coord == gnt_coord_s);
        end
    end

    bomb_slot_finder #(.N(NUM_SLOTS), .W(SLOT_W)) u_free_finder (
        .req   (free_vec_s),
        .found (free_found_s),
        .idx   (free_idx_s)
    );

    bomb_slot_finder #(.N(NUM_SLOTS), .W(SLOT_W)) u_exp_finder (
        .req   (exp_vec_s),
        .found (exp_found_s),
        .idx   (exp_sel_idx_s)
    );

    // Pick which pending request is evaluated this cycle.
    always_comb begin
        contested_s = pend_valid_r[0] & pend_valid_r[1];
        gnt_any_s   = pend_valid_r[0] | pend_valid_r[1];
        if (contested_s) begin
            gnt_player_s = rr_r;
        end else if (pend_valid_r[1]) begin
            gnt_player_s = P2;
        end else begin
            gnt_player_s = P1;
        end
        if (gnt_player_s == P2) begin
            gnt_coord_s = pend_coord_r[1];
            gnt_power_s = pend_power_r[1];
            gnt_count_s = num_2_r;
            gnt_max_s   = bomb_max_2;
        end else begin
            gnt_coord_s = pend_coord_r[0];
            gnt_power_s = pend_power_r[0];
            gnt_count_s = num_1_r;
            gnt_max_s   = bomb_max_1;
        end
    end

    // Evaluate the granted request: duplicate, over limit, table full or insert.
    always_comb begin
        hit_s    = |match_vec_s;
        limit_s  = (gnt_count_s >= gnt_max_s);
        insert_s = gnt_any_s & ~hit_s & ~limit_s & free_found_s;
        // A dropped or inserted request leaves pending; a full table keeps it.
        retire_s = gnt_any_s & (hit_s | limit_s | free_found_s);
    end

    // Explosion FSM next-state logic.
    always_comb begin
        case (state_r)
            EXP_IDLE: begin
                if (exp_found_s) begin
                    state_nxt_s = EXP_PRESENT;
                end else begin
                    state_nxt_s = EXP_IDLE;
                end
            end
            EXP_PRESENT: begin
                if (free_s) begin
                    state_nxt_s = EXP_IDLE;
                end else begin
                    state_nxt_s = EXP_PRESENT;
                end
            end
            default: state_nxt_s = EXP_IDLE;
        endcase
    end

    // Explosion FSM control outputs: latch a new bomb or retire the presented one.
    always_comb begin
        case (state_r)
            EXP_IDLE: begin
                load_s = exp_found_s;
                free_s = 1'b0;
            end
            EXP_PRESENT: begin
                load_s = 1'b0;
                free_s = exp_valid_r & explode_ready;
            end
            default: begin
                load_s = 1'b0;
                free_s = 1'b0;
            end
        endcase
    end

    // Next slot contents: free, insert, force-detonate, or fuse step.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slots_nxt_s[i] = slots_r[i];
            if (free_s && (exp_idx_r == SLOT_W'(i))) begin
                slots_nxt_s[i] = '0;
            end else if (insert_s && (free_idx_s == SLOT_W'(i))) begin
                slots_nxt_s[i].valid   = 1'b1;
                slots_nxt_s[i].expired = 1'b0;
                slots_nxt_s[i].owner   = gnt_player_s;
                slots_nxt_s[i].coord   = gnt_coord_s;
                slots_nxt_s[i].power   = gnt_power_s;
                slots_nxt_s[i].fuse    = fuse_t'(FUSE_TICKS);
            end else if (det_valid && slots_r[i].valid && !slots_r[i].expired &&
                         (slots_r[i].coord == det_coord)) begin
                slots_nxt_s[i].expired = 1'b1;
                slots_nxt_s[i].fuse    = 4'd0;
            end else if (tick && slots_r[i].valid && !slots_r[i].expired) begin
                slots_nxt_s[i] = slot_tick(slots_r[i]);
            end else begin
                slots_nxt_s[i] = slots_r[i];
            end
        end
    end

    // Per-owner live counts; an insert and a free for the same owner cancel.
    always_comb begin
        case ({insert_s & (gnt_player_s == P1), free_s & (exp_owner_r == P1)})
            2'b10:   num_1_nxt_s = num_1_r + 3'd1;
            2'b01:   num_1_nxt_s = num_1_r - 3'd1;
            default: num_1_nxt_s = num_1_r;
        endcase
        case ({insert_s & (gnt_player_s == P2), free_s & (exp_owner_r == P2)})
            2'b10:   num_2_nxt_s = num_2_r + 3'd1;
            2'b01:   num_2_nxt_s = num_2_r - 3'd1;
            default: num_2_nxt_s = num_2_r;
        endcase
    end

    // Slot table and live-count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_r[i] <= '0;
            end
            num_1_r <= 3'd0;
            num_2_r <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_r[i] <= slots_nxt_s[i];
            end
            num_1_r <= num_1_nxt_s;
            num_2_r <= num_2_nxt_s;
        end
    end

    // Pending request capture and the round-robin pointer, which only moves
    // when both players were competing for the same evaluation slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_r <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                pend_coord_r[p] <= 8'h00;
                pend_power_r[p] <= 2'd0;
            end
            rr_r <= P1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!pend_valid_r[p]) begin
                    if (set_s[p]) begin
                        pend_valid_r[p] <= 1'b1;
                        pend_coord_r[p] <= set_coord_s[p];
                        pend_power_r[p] <= set_power_s[p];
                    end
                end else if (retire_s && (int'(gnt_player_s) == p)) begin
                    pend_valid_r[p] <= 1'b0;
                end
            end
            if (retire_s && contested_s) begin
                rr_r <= (rr_r == P1) ? P2 : P1;
            end
        end
    end

    // Explosion FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= EXP_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Presented-bomb registers, held stable until the consumer accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_valid_r <= 1'b0;
            exp_coord_r <= 8'h00;
            exp_power_r <= 2'd0;
            exp_owner_r <= P1;
            exp_idx_r   <= '0;
        end else if (load_s) begin
            exp_valid_r <= 1'b1;
            exp_coord_r <= slots_r[exp_sel_idx_s].coord;
            exp_power_r <= slots_r[exp_sel_idx_s].power;
            exp_owner_r <= slots_r[exp_sel_idx_s].owner;
            exp_idx_r   <= exp_sel_idx_s;
        end else if (free_s) begin
            exp_valid_r <= 1'b0;
        end
    end

    assign bomb_num_1    = num_1_r;
    assign bomb_num_2    = num_2_r;
    assign explode_valid = exp_valid_r;
    assign explode_coord = exp_coord_r;
    assign explode_power = exp_power_r;
    assign explode_owner = exp_owner_r;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Self-checking bench for bomb_scheduler: expected explosions are queued as
// bombs are placed and compared as the scheduler presents them.
module tb_bomb_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       p1_set_bomb;
    logic [7:0] p1_coordinate;
    logic [1:0] p1_power;
    logic       p2_set_bomb;
    logic [7:0] p2_coordinate;
    logic [1:0] p2_power;
    logic [2:0] bomb_max_1;
    logic [2:0] bomb_max_2;
    logic       det_valid;
    logic [7:0] det_coord;
    logic [2:0] bomb_num_1;
    logic [2:0] bomb_num_2;
    logic       explode_valid;
    logic       explode_ready;
    logic [7:0] explode_coord;
    logic [1:0] explode_power;
    logic       explode_owner;

    typedef struct {
        logic [7:0] coord;
        logic [1:0] power;
        logic       owner;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bomb_scheduler #(.NUM_SLOTS(8), .FUSE_TICKS(3), .SLOT_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .p1_set_bomb   (p1_set_bomb),
        .p1_coordinate (p1_coordinate),
        .p1_power      (p1_power),
        .p2_set_bomb   (p2_set_bomb),
        .p2_coordinate (p2_coordinate),
        .p2_power      (p2_power),
        .bomb_max_1    (bomb_max_1),
        .bomb_max_2    (bomb_max_2),
        .det_valid     (det_valid),
        .det_coord     (det_coord),
        .bomb_num_1    (bomb_num_1),
        .bomb_num_2    (bomb_num_2),
        .explode_valid (explode_valid),
        .explode_ready (explode_ready),
        .explode_coord (explode_coord),
        .explode_power (explode_power),
        .explode_owner (explode_owner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] c, input logic [1:0] pw, input logic own);
        exp_t e;
        e.coord = c;
        e.power = pw;
        e.owner = own;
        sb_q.push_back(e);
    endtask

    task automatic place(input logic who, input logic [7:0] c, input logic [1:0] pw);
        if (who == 1'b0) begin
            p1_set_bomb = 1'b1; p1_coordinate = c; p1_power = pw;
        end else begin
            p2_set_bomb = 1'b1; p2_coordinate = c; p2_power = pw;
        end
        step();
        p1_set_bomb = 1'b0;
        p2_set_bomb = 1'b0;
        step();
    endtask

    task automatic place_both(input logic [7:0] c1, input logic [1:0] w1,
                              input logic [7:0] c2, input logic [1:0] w2);
        p1_set_bomb = 1'b1; p1_coordinate = c1; p1_power = w1;
        p2_set_bomb = 1'b1; p2_coordinate = c2; p2_power = w2;
        step();
        p1_set_bomb = 1'b0;
        p2_set_bomb = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic detonate(input logic [7:0] c);
        det_valid = 1'b1;
        det_coord = c;
        step();
        det_valid = 1'b0;
    endtask

    // Wait for the next presented bomb, compare it with the scoreboard head,
    // hold ready low for 'hold' cycles checking stability, then accept it.
    task automatic expect_explode(input int budget, input int hold, input string tag);
        exp_t e;
        int   waited;
        waited = 0;
        while (explode_valid !== 1'b1 && waited < budget) begin
            step();
            waited++;
        end
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, explode_valid=%b", tag, explode_valid);
            return;
        end
        e = sb_q.pop_front();
        if (explode_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s timeout: explode_valid=%b required 1 within %0d cycles",
                     tag, explode_valid, budget);
            return;
        end
        for (int k = 0; k <= hold; k++) begin
            n_cmp++;
            if ({explode_valid, explode_coord, explode_power, explode_owner} !==
                {1'b1, e.coord, e.power, e.owner}) begin
                n_bad++;
                $display("FAIL %s[%0d]: v/coord/pow/own=%b/%h/%0d/%0d required 1/%h/%0d/%0d",
                         tag, k, explode_valid, explode_coord, explode_power, explode_owner,
                         e.coord, e.power, e.owner);
            end
            if (k < hold) step();
        end
        explode_ready = 1'b1;
        step();
        explode_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_cmp++;
        if ({explode_valid, explode_coord, explode_power, explode_owner, bomb_num_1, bomb_num_2} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_hold: outputs=%b/%h/%0d/%0d/%0d/%0d required all 0",
                     explode_valid, explode_coord, explode_power, explode_owner, bomb_num_1, bomb_num_2);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({explode_valid, bomb_num_1, bomb_num_2} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_release: valid/n1/n2=%b/%0d/%0d required 0/0/0",
                     explode_valid, bomb_num_1, bomb_num_2);
        end
    endtask

    task automatic test_single();
        place(1'b0, 8'h23, 2'd1);
        n_cmp++;
        if (bomb_num_1 !== 3'd1) begin
            n_bad++;
            $display("FAIL single_count: bomb_num_1=%0d required 1", bomb_num_1);
        end
        push_exp(8'h23, 2'd1, 1'b0);
        do_ticks(2);
        step();
        n_cmp++;
        if (explode_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early: explode_valid=%b required 0 after 2 ticks", explode_valid);
        end
        do_ticks(1);
        expect_explode(3, 0, "single_explode");
        n_cmp++;
        if ({explode_valid, bomb_num_1} !== 4'b0_000) begin
            n_bad++;
            $display("FAIL single_free: valid/bomb_num_1=%b/%0d required 0/0", explode_valid, bomb_num_1);
        end
    endtask

    task automatic test_rr();
        place_both(8'h11, 2'd0, 8'h22, 2'd1);
        step();
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== {3'd1, 3'd0}) begin
            n_bad++;
            $display("FAIL rr_first: n1/n2=%0d/%0d required 1/0", bomb_num_1, bomb_num_2);
        end
        step();
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== {3'd1, 3'd1}) begin
            n_bad++;
            $display("FAIL rr_second: n1/n2=%0d/%0d required 1/1", bomb_num_1, bomb_num_2);
        end
        place_both(8'h33, 2'd2, 8'h44, 2'd3);
        step();
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== {3'd1, 3'd2}) begin
            n_bad++;
            $display("FAIL rr_flip: n1/n2=%0d/%0d required 1/2", bomb_num_1, bomb_num_2);
        end
        step();
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== {3'd2, 3'd2}) begin
            n_bad++;
            $display("FAIL rr_flip2: n1/n2=%0d/%0d required 2/2", bomb_num_1, bomb_num_2);
        end
        // Same cell from both players: pointer is back on P1, P2 loses to the duplicate check.
        place_both(8'h30, 2'd1, 8'h30, 2'd2);
        step();
        step();
        step();
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== {3'd3, 3'd2}) begin
            n_bad++;
            $display("FAIL same_coord: n1/n2=%0d/%0d required 3/2", bomb_num_1, bomb_num_2);
        end
        push_exp(8'h11, 2'd0, 1'b0);
        push_exp(8'h22, 2'd1, 1'b1);
        push_exp(8'h44, 2'd3, 1'b1);
        push_exp(8'h33, 2'd2, 1'b0);
        push_exp(8'h30, 2'd1, 1'b0);
        do_ticks(3);
        for (int k = 0; k < 5; k++) expect_explode(4, 0, "rr_order");
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== 6'd0) begin
            n_bad++;
            $display("FAIL rr_drain: n1/n2=%0d/%0d required 0/0", bomb_num_1, bomb_num_2);
        end
    endtask

    task automatic test_limit();
        bomb_max_1 = 3'd2;
        place(1'b0, 8'h01, 2'd0);
        place(1'b0, 8'h02, 2'd1);
        place(1'b0, 8'h03, 2'd2);
        step();
        n_cmp++;
        if (bomb_num_1 !== 3'd2) begin
            n_bad++;
            $display("FAIL limit_count: bomb_num_1=%0d required 2", bomb_num_1);
        end
        push_exp(8'h01, 2'd0, 1'b0);
        push_exp(8'h02, 2'd1, 1'b0);
        do_ticks(3);
        expect_explode(4, 0, "limit_a");
        expect_explode(4, 0, "limit_b");
        step();
        step();
        step();
        n_cmp++;
        if ({explode_valid, bomb_num_1} !== 4'b0_000) begin
            n_bad++;
            $display("FAIL limit_third: valid/bomb_num_1=%b/%0d required 0/0", explode_valid, bomb_num_1);
        end
        bomb_max_1 = 3'd7;
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) place(i[0], 8'h80 + 8'(i), 2'(i));
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== {3'd4, 3'd4}) begin
            n_bad++;
            $display("FAIL full_fill: n1/n2=%0d/%0d required 4/4", bomb_num_1, bomb_num_2);
        end
        p2_set_bomb = 1'b1; p2_coordinate = 8'h99; p2_power = 2'd2;
        step();
        p2_set_bomb = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_cmp++;
        if (bomb_num_2 !== 3'd4) begin
            n_bad++;
            $display("FAIL full_pending: bomb_num_2=%0d required 4", bomb_num_2);
        end
        push_exp(8'h80, 2'd0, 1'b0);
        detonate(8'h80);
        expect_explode(3, 0, "full_det");
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== {3'd3, 3'd4}) begin
            n_bad++;
            $display("FAIL full_freed: n1/n2=%0d/%0d required 3/4", bomb_num_1, bomb_num_2);
        end
        step();
        n_cmp++;
        if (bomb_num_2 !== 3'd5) begin
            n_bad++;
            $display("FAIL full_refill: bomb_num_2=%0d required 5", bomb_num_2);
        end
        push_exp(8'h99, 2'd2, 1'b1);
        for (int i = 1; i < 8; i++) push_exp(8'h80 + 8'(i), 2'(i), i[0]);
        do_ticks(3);
        for (int k = 0; k < 8; k++) expect_explode(4, 0, "full_drain");
        n_cmp++;
        if ({bomb_num_1, bomb_num_2} !== 6'd0) begin
            n_bad++;
            $display("FAIL full_empty: n1/n2=%0d/%0d required 0/0", bomb_num_1, bomb_num_2);
        end
    endtask

    task automatic test_back_to_back();
        place(1'b0, 8'h50, 2'd1);
        place(1'b1, 8'h60, 2'd2);
        push_exp(8'h50, 2'd1, 1'b0);
        push_exp(8'h60, 2'd2, 1'b1);
        do_ticks(3);
        expect_explode(4, 5, "stall_first");
        n_cmp++;
        if (explode_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_gap: explode_valid=%b required 0", explode_valid);
        end
        expect_explode(2, 0, "stall_second");
    endtask

    task automatic test_detonate();
        place(1'b0, 8'h45, 2'd3);
        detonate(8'h46);
        step();
        step();
        step();
        n_cmp++;
        if (explode_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL det_miss: explode_valid=%b required 0", explode_valid);
        end
        push_exp(8'h45, 2'd3, 1'b0);
        detonate(8'h45);
        expect_explode(3, 0, "det_hit");
        n_cmp++;
        if (bomb_num_1 !== 3'd0) begin
            n_bad++;
            $display("FAIL det_free: bomb_num_1=%0d required 0", bomb_num_1);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        place(1'b1, 8'h77, 2'd1);
        detonate(8'h77);
        waited = 0;
        while (explode_valid !== 1'b1 && waited < 3) begin
            step();
            waited++;
        end
        n_cmp++;
        if (explode_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_setup: explode_valid=%b required 1", explode_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({explode_valid, explode_coord, explode_power, explode_owner, bomb_num_2} !== 15'd0) begin
            n_bad++;
            $display("FAIL rstmid_clear: v/coord/pow/own/n2=%b/%h/%0d/%0d/%0d required all 0",
                     explode_valid, explode_coord, explode_power, explode_owner, bomb_num_2);
        end
        #1;
        rst = 1'b1;
        step();
        step();
        step();
        n_cmp++;
        if ({explode_valid, bomb_num_1, bomb_num_2} !== 7'd0) begin
            n_bad++;
            $display("FAIL rstmid_after: valid/n1/n2=%b/%0d/%0d required 0/0/0",
                     explode_valid, bomb_num_1, bomb_num_2);
        end
    endtask

    initial begin
        rst           = 1'b0;
        tick          = 1'b0;
        p1_set_bomb   = 1'b0;
        p1_coordinate = 8'h00;
        p1_power      = 2'd0;
        p2_set_bomb   = 1'b0;
        p2_coordinate = 8'h00;
        p2_power      = 2'd0;
        bomb_max_1    = 3'd7;
        bomb_max_2    = 3'd7;
        det_valid     = 1'b0;
        det_coord     = 8'h00;
        explode_ready = 1'b0;

        test_reset();
        test_single();
        test_rr();
        test_limit();
        test_full();
        test_back_to_back();
        test_detonate();
        test_reset_mid();

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d entries remain, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
Owns the shared bomb slot table for both players. It accepts bomb-placement pulses from the player controller, arbitrates them into a fixed pool of slots, and counts down each bomb's fuse on the game tick. Expired bombs are handed one at a time to the explosion/flame block over a valid/ready handshake. It also returns per-player live-bomb counts, which the controller uses for its bomb_num limit checks.

Parameters:
NUM_SLOTS, 8, number of simultaneous bombs on the board (both players combined)
FUSE_TICKS, 3, tick pulses from placement to expiry (1..15)
SLOT_W, 3, log2(NUM_SLOTS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick  in  1  one-cycle fuse-decrement strobe (frame-rate divider)
p1_set_bomb  in  1  P1 placement pulse
p1_coordinate  in  8  P1 cell, 16*y+x
p1_power  in  2  P1 flame range
p2_set_bomb, p2_coordinate, p2_power  in  1/8/2  same for P2
bomb_max_1, bomb_max_2  in  3  per-player bomb limit
det_valid  in  1  force-detonate request (chain reaction from flames)
det_coord  in  8  cell to force-detonate
bomb_num_1, bomb_num_2  out  3  live bombs owned per player
explode_valid  out  1  expired bomb presented
explode_ready  in  1  consumer accepts
explode_coord  out  8  cell of presented bomb
explode_power  out  2  range of presented bomb
explode_owner  out  1  0=P1, 1=P2

Behaviour:
- Reset values: all slots invalid, pending registers clear, bomb_num_* = 0, explode_valid = 0, explode_coord/power/owner = 0, RR pointer = P1.
- Slot fields: valid, expired, owner, coord[7:0], power[1:0], fuse[3:0].
- Request capture: a set pulse loads the player's 1-deep pending register (coord, power). A new pulse while pending is occupied is dropped.
- Arbitration:
  - At most one insertion per cycle.
  - If both players are pending, the RR pointer chooses; the pointer flips to the other player after each grant.
  - A pending request is evaluated in the cycle after capture, so the minimum set-to-slot latency is 2 cycles.
- Evaluation of the granted request, in priority order:
  - coord matches any valid slot -> drop, clear pending.
  - owner's bomb_num >= bomb_max -> drop, clear pending.
  - no free slot -> keep pending, retry next cycle. The RR pointer does not flip.
  - otherwise -> insert into the lowest-index free slot with fuse = FUSE_TICKS, expired = 0, and clear pending.
- Fuse:
  - On tick, every valid, non-expired slot decrements its fuse.
  - A slot whose fuse goes 1 -> 0 sets expired in the same update.
  - A slot inserted in the same cycle as a tick is not decremented.
- Detonate: when det_valid is high, a valid, non-expired slot with coord == det_coord sets expired next cycle (fuse forced to 0). No match -> ignored.
- Output FSM, two states:
  - IDLE: if any expired slot exists, latch the lowest-index expired slot into explode_*, set explode_valid, record the slot index, go to PRESENT.
  - PRESENT: outputs are held stable while explode_ready = 0. When explode_valid && explode_ready, free the recorded slot (valid = 0, expired = 0), drop explode_valid next cycle, return to IDLE.
  - Back-to-back expired bombs are therefore presented with at least one idle cycle between them.
- Counts:
  - bomb_num_x is a registered count of valid slots with owner x.
  - Insertion and free in the same cycle for the same owner -> count unchanged.
  - A freed slot is usable for insertion the cycle after the handshake.
- Simultaneous set pulses from both players with the same coord: the RR winner inserts; the loser is dropped by the coord-match rule next cycle.
- Reset asserted mid-operation clears everything immediately; an in-flight explosion is lost.

Decomposition:
- Shared package game_pkg: player-id typedef (P1/P2), coordinate typedef (8 bit), power typedef, slot struct (valid, expired, owner, coord, power, fuse), DIR constants UP/DOWN/LEFT/RIGHT/STOP.
- Sub-module bomb_slot_finder: combinational lowest-index search over the slot vector. Two instances: free slot and expired slot.

Test Plan:
- P1 set at coord 0x23, power 1, FUSE_TICKS = 3 -> slot0 valid 2 cycles later, bomb_num_1 = 1. After 3 ticks: explode_valid = 1, coord 0x23, owner 0. Ready high -> bomb_num_1 = 0 next cycle.
- P1 and P2 set in the same cycle at 0x11/0x22 -> P1 inserted first, P2 one cycle later. Next simultaneous pair -> P2 granted first.
- bomb_max_1 = 2 with three P1 sets at distinct cells -> only two slots filled, third dropped, bomb_num_1 = 2.
- Fill all 8 slots, then a P2 request arrives -> stays pending. Complete one explosion handshake -> P2 inserted into the freed slot the next cycle.
- Two bombs expire on the same tick and explode_ready is held low 5 cycles -> explode_* stable for those cycles. Bombs are then presented in index order with a one-cycle gap.
- det_valid at coord 0x45 with a live bomb whose fuse = 3 -> explode_valid with coord 0x45 within 3 cycles, no tick required.
- rst pulled low while explode_valid = 1 -> all outputs 0 immediately; bomb_num_* = 0 after release.
